// File: rtl/hough_stream_driver.sv
// hough_stream_driver
//   Framing adapter around hough_top.
//   Input side : RGB valid/ready stream with sop/eop -> pipeline input FIFO
//                write port. Every frame that starts with sop is written as
//                exactly IMAGE_SIZE pixels. Short frames are zero padded and
//                long frames are truncated.
//   Output side: pops the first-word fall-through result FIFO into a
//                one-entry output register and presents it as a valid/ready
//                stream with sop/eop every IMAGE_SIZE beats.
// Ports
//   clock, reset (async, active low)
//   src_valid/src_ready/src_data/src_sop/src_eop : input pixel stream
//   image_wr_en/image_din/image_full             : pipeline input FIFO write
//   img_out_rd_en/img_out_empty/img_out_dout     : result FIFO read (FWFT)
//   snk_valid/snk_ready/snk_data/snk_sop/snk_eop : output pixel stream
//   err_short/err_long/err_clear                 : sticky frame-repair flags
//   frame_done                                   : pulse after output eop
module hough_stream_driver #(
    parameter int WIDTH      = 512,
    parameter int HEIGHT     = 288,
    localparam int IMAGE_SIZE = WIDTH * HEIGHT,
    localparam int CW         = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        src_valid,
    output logic        src_ready,
    input  logic [23:0] src_data,
    input  logic        src_sop,
    input  logic        src_eop,
    output logic        image_wr_en,
    output logic [23:0] image_din,
    input  logic        image_full,
    output logic        img_out_rd_en,
    input  logic        img_out_empty,
    input  logic [7:0]  img_out_dout,
    output logic        snk_valid,
    input  logic        snk_ready,
    output logic [7:0]  snk_data,
    output logic        snk_sop,
    output logic        snk_eop,
    output logic        err_short,
    output logic        err_long,
    input  logic        err_clear,
    output logic        frame_done
);

    localparam logic [CW-1:0] LAST = CW'(IMAGE_SIZE - 1);

    typedef enum logic [1:0] {IDLE, STREAM, PAD, DROP} state_t;

    state_t       state_q;
    logic [CW-1:0] in_cnt_q;
    logic         err_short_q, err_long_q;
    logic         set_short, set_long;
    logic         cnt_last;

    // ---------------------------------------------------------------
    // Input path: combinational handshake and FIFO write
    // ---------------------------------------------------------------
    always_comb begin
        src_ready   = 1'b1;
        image_wr_en = 1'b0;
        image_din   = '0;
        case (state_q)
            IDLE: begin
                // Only a sop beat needs FIFO space; others are dropped freely.
                src_ready   = ~(src_sop & image_full);
                image_wr_en = src_valid & src_sop & ~image_full;
                image_din   = image_wr_en ? src_data : '0;
            end
            STREAM: begin
                src_ready   = ~image_full;
                image_wr_en = src_valid & ~image_full;
                image_din   = src_data;
            end
            PAD: begin
                src_ready   = 1'b0;
                image_wr_en = ~image_full;
            end
            default: src_ready = 1'b1;
        endcase
    end

    assign cnt_last = (in_cnt_q == LAST);

    // A write in IDLE is the write at count 0, so IDLE and STREAM share
    // the end-of-frame rules (this also covers IMAGE_SIZE == 1).
    always_comb begin
        set_short = 1'b0;
        set_long  = 1'b0;
        if ((state_q == IDLE || state_q == STREAM) && image_wr_en) begin
            set_long  = cnt_last & ~src_eop;
            set_short = ~cnt_last & src_eop;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            in_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE, STREAM: begin
                    if (image_wr_en) begin
                        if (cnt_last) begin
                            state_q  <= src_eop ? IDLE : DROP;
                            in_cnt_q <= '0;
                        end else begin
                            state_q  <= src_eop ? PAD : STREAM;
                            in_cnt_q <= in_cnt_q + CW'(1);
                        end
                    end
                end
                PAD: begin
                    if (image_wr_en) begin
                        if (cnt_last) begin
                            state_q  <= IDLE;
                            in_cnt_q <= '0;
                        end else begin
                            in_cnt_q <= in_cnt_q + CW'(1);
                        end
                    end
                end
                DROP: begin
                    if (src_valid & src_eop) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky flags; a clear wins over a set in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else if (err_clear) begin
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            err_short_q <= err_short_q | set_short;
            err_long_q  <= err_long_q | set_long;
        end
    end

    assign err_short = err_short_q;
    assign err_long  = err_long_q;

    // ---------------------------------------------------------------
    // Output path: one-entry skid register fed from the FWFT FIFO
    // ---------------------------------------------------------------
    logic          snk_valid_q, snk_sop_q, snk_eop_q, frame_done_q;
    logic [7:0]    snk_data_q;
    logic [CW-1:0] out_cnt_q;
    logic          pop;

    assign pop           = ~img_out_empty & (~snk_valid_q | snk_ready);
    assign img_out_rd_en = pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snk_valid_q  <= 1'b0;
            snk_sop_q    <= 1'b0;
            snk_eop_q    <= 1'b0;
            snk_data_q   <= '0;
            out_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= snk_valid_q & snk_ready & snk_eop_q;
            if (pop) begin
                snk_valid_q <= 1'b1;
                snk_data_q  <= img_out_dout;
                snk_sop_q   <= (out_cnt_q == '0);
                snk_eop_q   <= (out_cnt_q == LAST);
                out_cnt_q   <= (out_cnt_q == LAST) ? '0 : out_cnt_q + CW'(1);
            end else if (snk_ready) begin
                snk_valid_q <= 1'b0;
            end
        end
    end

    assign snk_valid  = snk_valid_q;
    assign snk_data   = snk_data_q;
    assign snk_sop    = snk_sop_q;
    assign snk_eop    = snk_eop_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_hough_stream_driver.sv
module tb_hough_stream_driver;
    localparam int N = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        src_valid = 1'b0, src_sop = 1'b0, src_eop = 1'b0;
    logic [23:0] src_data = '0;
    logic        src_ready;
    logic        image_wr_en;
    logic [23:0] image_din;
    logic        image_full = 1'b0;
    logic        img_out_rd_en;
    logic        img_out_empty = 1'b1;
    logic [7:0]  img_out_dout = '0;
    logic        snk_valid, snk_sop, snk_eop;
    logic        snk_ready = 1'b1;
    logic [7:0]  snk_data;
    logic        err_short, err_long, frame_done;
    logic        err_clear = 1'b0;

    hough_stream_driver #(.WIDTH(4), .HEIGHT(2)) dut (
        .clock(clock), .reset(reset),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .src_sop(src_sop), .src_eop(src_eop),
        .image_wr_en(image_wr_en), .image_din(image_din), .image_full(image_full),
        .img_out_rd_en(img_out_rd_en), .img_out_empty(img_out_empty),
        .img_out_dout(img_out_dout),
        .snk_valid(snk_valid), .snk_ready(snk_ready), .snk_data(snk_data),
        .snk_sop(snk_sop), .snk_eop(snk_eop),
        .err_short(err_short), .err_long(err_long), .err_clear(err_clear),
        .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        nvec++;
        nerr++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // ---------------- model state ----------------
    logic [23:0] wq[$];        // expected FIFO writes, in order
    logic [7:0]  rq[$];        // result FIFO contents
    logic [7:0]  eq[$];        // bytes popped, expected on the sink in order
    logic [7:0]  sop_b[$], eop_b[$];
    bit          exp_s = 0, exp_l = 0;
    int          nwr = 0, k = 0, acc_cnt = 0, fd_cnt = 0;
    bit          fd_exp = 0, stall = 0, pop_pend = 0;
    logic [9:0]  prev = '0;

    int full_mode = 0, rdy_mode = 0, push_target = 0, pushed = 0;
    bit burst = 0;

    always @(posedge clock) begin
        #1;
        case (full_mode)
            0:       image_full = 1'b0;
            1:       image_full = ~image_full;
            default: image_full = ($urandom % 3 == 0);
        endcase
    end

    // Result FIFO model (first-word fall-through) and sink ready.
    always @(posedge clock) begin
        #1;
        if (pop_pend && rq.size() > 0) rq.delete(0);
        if (burst) begin
            while (pushed < push_target) begin
                rq.push_back(8'(pushed));
                pushed++;
            end
        end else if (pushed < push_target && ($urandom % 4 != 0)) begin
            rq.push_back(8'($urandom));
            pushed++;
        end
        img_out_empty = (rq.size() == 0);
        img_out_dout  = (rq.size() == 0) ? 8'h00 : rq[0];
        snk_ready     = (rdy_mode == 0) ? 1'b1 : 1'($urandom % 2);
    end

    // Per-cycle compare against the model.
    always @(negedge clock) begin
        pop_pend = img_out_rd_en;
        if (!reset) begin
            k = 0;
            eq.delete();
            fd_exp = 0;
            stall = 0;
        end else begin
            if (image_wr_en) begin
                nwr++;
                chk("wr_while_full", image_full, 0);
                if (wq.size() == 0) fail("unexpected_write");
                else chk("image_din", image_din, wq.pop_front());
            end
            chk("img_out_rd_en", img_out_rd_en, !img_out_empty && (!snk_valid || snk_ready));
            chk("frame_done", frame_done, fd_exp);
            if (frame_done) fd_cnt++;
            if (stall) begin
                chk("hold_valid", snk_valid, 1);
                chk("hold_beat", {snk_data, snk_sop, snk_eop}, prev);
            end
            fd_exp = 0;
            if (snk_valid && snk_ready) begin
                if (eq.size() == 0) fail("unexpected_sink_beat");
                else chk("snk_data", snk_data, eq.pop_front());
                chk("snk_sop", snk_sop, k == 0);
                chk("snk_eop", snk_eop, k == N - 1);
                if (snk_sop) sop_b.push_back(snk_data);
                if (snk_eop) eop_b.push_back(snk_data);
                fd_exp = (k == N - 1);
                k = (k + 1) % N;
                acc_cnt++;
            end
            stall = snk_valid && !snk_ready;
            prev  = {snk_data, snk_sop, snk_eop};
            if (img_out_rd_en) eq.push_back(img_out_dout);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic beat(input logic [23:0] d, input bit s, input bit e);
        int t;
        src_valid = 1'b1; src_data = d; src_sop = s; src_eop = e;
        t = 0;
        while (1) begin
            @(negedge clock);
            if (src_ready) break;
            t++;
            if (t > 300) begin
                fail("src_ready_timeout");
                break;
            end
        end
        sync();
        src_valid = 1'b0; src_sop = 1'b0; src_eop = 1'b0;
    endtask

    // A frame of L beats is written as its first min(L,N) pixels then zeros.
    task automatic frame(input int L);
        logic [23:0] d[$];
        for (int i = 0; i < L; i++) d.push_back(24'($urandom));
        for (int i = 0; i < N; i++) wq.push_back(i < L ? d[i] : 24'h0);
        if (!err_clear) begin
            if (L < N) exp_s = 1;
            if (L > N) exp_l = 1;
        end
        for (int i = 0; i < L; i++) beat(d[i], i == 0, i == L - 1);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (wq.size() != 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (wq.size() != 0) fail("write_drain_timeout");
        repeat (2) @(negedge clock);
    endtask

    task automatic check_flags();
        chk("err_short", err_short, exp_s);
        chk("err_long", err_long, exp_l);
    endtask

    task automatic clr();
        sync();
        err_clear = 1'b1;
        sync();
        err_clear = 1'b0;
        exp_s = 0;
        exp_l = 0;
        @(negedge clock);
        check_flags();
        sync();
    endtask

    task automatic reset_checks();
        chk("rst_src_ready", src_ready, 1);
        chk("rst_wr_en", image_wr_en, 0);
        chk("rst_din", image_din, 0);
        chk("rst_snk_valid", snk_valid, 0);
        chk("rst_snk_sop", snk_sop, 0);
        chk("rst_snk_eop", snk_eop, 0);
        chk("rst_snk_data", snk_data, 0);
        chk("rst_err_short", err_short, 0);
        chk("rst_err_long", err_long, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_rd_en", img_out_rd_en, !img_out_empty);
    endtask

    task automatic wait_acc(input int target);
        int t = 0;
        while (acc_cnt < target && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (acc_cnt < target) fail("sink_timeout");
    endtask

    initial begin
        int w0, ab, sb;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_checks();
        sync();
        reset = 1'b1;
        sync();

        // Normal frame
        w0 = nwr;
        frame(8);
        wait_idle();
        chk("normal_writes", nwr - w0, 8);
        check_flags();
        chk("normal_no_short", err_short, 0);
        sync();

        // Short frame: three pad cycles with src_ready low
        w0 = nwr;
        frame(5);
        for (int j = 0; j < 3; j++) begin
            @(negedge clock);
            chk("pad_ready_low", src_ready, 0);
        end
        @(negedge clock);
        chk("idle_ready_after_pad", src_ready, 1);
        wait_idle();
        chk("short_writes", nwr - w0, 8);
        chk("short_flag_lit", err_short, 1);
        check_flags();
        clr();

        // Long frame then a normal one
        w0 = nwr;
        frame(11);
        wait_idle();
        chk("long_writes", nwr - w0, 8);
        chk("long_flag_lit", err_long, 1);
        check_flags();
        sync();
        frame(8);
        wait_idle();
        check_flags();
        clr();

        // Clear held during a short frame keeps the flag low
        err_clear = 1'b1;
        frame(3);
        wait_idle();
        sync();
        err_clear = 1'b0;
        @(negedge clock);
        check_flags();
        sync();

        // Backpressure and stray beats in IDLE
        full_mode = 1;
        w0 = nwr;
        beat(24'hABCDEF, 0, 0);
        beat(24'h123456, 0, 1);
        frame(8);
        beat(24'h777777, 0, 0);
        frame(6);
        wait_idle();
        chk("bp_writes", nwr - w0, 16);
        check_flags();
        clr();
        full_mode = 0;

        // Output stream: 16 preloaded bytes, random ready
        rdy_mode = 1;
        burst = 1;
        push_target = 16;
        wait_acc(16);
        repeat (2) @(negedge clock);
        chk("frame_done_count", fd_cnt, 2);
        chk("sop_count", sop_b.size(), 2);
        chk("eop_count", eop_b.size(), 2);
        if (sop_b.size() == 2 && eop_b.size() == 2) begin
            chk("sop0_byte", sop_b[0], 8'h00);
            chk("sop1_byte", sop_b[1], 8'h08);
            chk("eop0_byte", eop_b[0], 8'h07);
            chk("eop1_byte", eop_b[1], 8'h0F);
        end
        sync();
        burst = 0;

        // Reset in the middle of an input and an output frame
        ab = acc_cnt;
        push_target = push_target + 30;
        for (int i = 0; i < 3; i++) wq.push_back(24'h100 + 24'(i));
        beat(24'h100, 1, 0);
        beat(24'h101, 0, 0);
        beat(24'h102, 0, 0);
        wait_acc(ab + 2);
        sync();
        reset = 1'b0;
        wq.delete();
        exp_s = 0;
        exp_l = 0;
        @(negedge clock);
        reset_checks();
        @(negedge clock);
        reset_checks();
        sync();
        reset = 1'b1;
        sync();
        sb = sop_b.size();
        ab = acc_cnt;
        frame(8);
        wait_idle();
        check_flags();
        wait_acc(ab + 1);
        chk("sop_after_reset", sop_b.size(), sb + 1);
        sync();

        // Randomized frames with random backpressure and strays
        full_mode = 2;
        push_target = push_target + 60;
        for (int f = 0; f < 15; f++) begin
            int ns = $urandom_range(0, 2);
            for (int s = 0; s < ns; s++) beat(24'($urandom), 0, 1'($urandom % 2));
            frame($urandom_range(1, 12));
            wait_idle();
            check_flags();
            if ($urandom % 2) clr();
            else sync();
        end
        full_mode = 0;

        begin
            int t = 0;
            while ((pushed < push_target || rq.size() != 0 || snk_valid) && t < 3000) begin
                @(negedge clock);
                t++;
            end
            if (t >= 3000) fail("final_drain_timeout");
        end
        repeat (10) @(negedge clock);
        chk("final_wq_empty", wq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
